// File: rtl/router_pkt_tx.sv
// Packet transmitter feeding the router input port: buffers a host payload,
// then sends header, payload and parity under busy flow control.
module router_pkt_tx #(
   parameter int MAX_LEN     = 63,
   parameter int GAP_CYCLES  = 2,
   parameter int STALL_LIMIT = 16
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic [1:0] req_addr,
   input  logic [5:0] req_len,
   input  logic       req_bad_parity,
   input  logic       pl_valid,
   input  logic [7:0] pl_data,
   output logic       pl_ready,
   input  logic       busy,
   output logic       pkt_valid,
   output logic [7:0] data_out,
   output logic       tx_done,
   output logic       addr_err,
   output logic       stall_timeout
);

   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] LOAD    = 3'd1;
   localparam logic [2:0] HEADER  = 3'd2;
   localparam logic [2:0] PAYLOAD = 3'd3;
   localparam logic [2:0] PARITY  = 3'd4;
   localparam logic [2:0] GAP     = 3'd5;

   localparam int ST_W = $clog2(STALL_LIMIT + 1);
   localparam logic [ST_W-1:0] STALL_MAX = ST_W'(STALL_LIMIT);
   localparam logic [ST_W-1:0] STALL_PRE = ST_W'(STALL_LIMIT - 1);
   localparam logic [3:0]      GAP_LAST  = 4'(GAP_CYCLES - 1);

   logic [2:0]      state;
   logic [1:0]      addr_q;
   logic [5:0]      len_q;
   logic            bad_q;
   logic [5:0]      wr_cnt;
   logic [5:0]      rd_ptr;
   logic [5:0]      rd_next;
   logic [3:0]      gap_cnt;
   logic [ST_W-1:0] stall_cnt;
   logic [7:0]      parity;
   logic [7:0]      header;
   logic [7:0]      parity_byte;
   logic [7:0]      pl_buf [0:MAX_LEN];

   assign req_ready   = (state == IDLE);
   assign pl_ready    = (state == LOAD);
   assign header      = {len_q, addr_q};
   assign parity_byte = parity ^ {8{bad_q}};
   assign rd_next     = rd_ptr + 6'd1;

   // Payload buffer holds data only, so it is deliberately left out of reset.
   always_ff @(posedge clock) begin
      if (state == LOAD && pl_valid)
         pl_buf[wr_cnt] <= pl_data;
   end

   // data_out/pkt_valid are loaded with the next byte on the accepting edge,
   // so a busy-free stream has no bubbles.
   always_ff @(posedge clock) begin
      if (reset) begin
         state         <= IDLE;
         addr_q        <= 2'd0;
         len_q         <= 6'd0;
         bad_q         <= 1'b0;
         wr_cnt        <= 6'd0;
         rd_ptr        <= 6'd0;
         gap_cnt       <= 4'd0;
         stall_cnt     <= '0;
         parity        <= 8'd0;
         pkt_valid     <= 1'b0;
         data_out      <= 8'd0;
         tx_done       <= 1'b0;
         addr_err      <= 1'b0;
         stall_timeout <= 1'b0;
      end else begin
         tx_done  <= 1'b0;
         addr_err <= 1'b0;
         case (state)
            IDLE: begin
               if (req_valid) begin
                  if (req_addr == 2'd3) begin
                     addr_err <= 1'b1;
                  end else begin
                     addr_q <= req_addr;
                     len_q  <= req_len;
                     bad_q  <= req_bad_parity;
                     parity <= {req_len, req_addr};
                     wr_cnt <= 6'd0;
                     if (req_len != 6'd0) begin
                        state <= LOAD;
                     end else begin
                        state     <= HEADER;
                        pkt_valid <= 1'b1;
                        data_out  <= {req_len, req_addr};
                     end
                  end
               end
            end
            LOAD: begin
               if (pl_valid) begin
                  parity <= parity ^ pl_data;
                  wr_cnt <= wr_cnt + 6'd1;
                  if (wr_cnt == len_q - 6'd1) begin
                     state     <= HEADER;
                     pkt_valid <= 1'b1;
                     data_out  <= header;
                  end
               end
            end
            HEADER: begin
               if (!busy) begin
                  rd_ptr <= 6'd0;
                  if (len_q == 6'd0) begin
                     state     <= PARITY;
                     pkt_valid <= 1'b0;
                     data_out  <= parity_byte;
                  end else begin
                     state    <= PAYLOAD;
                     data_out <= pl_buf[0];
                  end
               end
            end
            PAYLOAD: begin
               if (!busy) begin
                  if (rd_ptr == len_q - 6'd1) begin
                     state     <= PARITY;
                     pkt_valid <= 1'b0;
                     data_out  <= parity_byte;
                  end else begin
                     rd_ptr   <= rd_next;
                     data_out <= pl_buf[rd_next];
                  end
               end
            end
            PARITY: begin
               if (!busy) begin
                  state    <= GAP;
                  data_out <= 8'd0;
                  gap_cnt  <= 4'd0;
               end
            end
            GAP: begin
               if (gap_cnt == GAP_LAST) begin
                  state   <= IDLE;
                  tx_done <= 1'b1;
               end else begin
                  gap_cnt <= gap_cnt + 4'd1;
               end
            end
            default: state <= IDLE;
         endcase

         // Stall watchdog only flags; the byte stays presented.
         if (state == HEADER || state == PAYLOAD || state == PARITY) begin
            if (busy) begin
               if (stall_cnt != STALL_MAX)
                  stall_cnt <= stall_cnt + 1'b1;
               if (stall_cnt == STALL_PRE)
                  stall_timeout <= 1'b1;
            end else begin
               stall_cnt <= '0;
            end
         end
      end
   end

endmodule
